// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_STEP     = 4;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_WAIT  = 3'd2,
    FS_DRAIN = 3'd3,
    FS_HOLD  = 3'd4,
    FS_FAULT = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with redirect handling.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects trap to FAULT instead of being aligned down.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH_POW = 6,
  parameter int ADDR_WIDTH     = 1 << ADDR_WIDTH_POW,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk_in,
  input  logic                   reset,
  output logic                   mem_req_out,
  output logic [ADDR_WIDTH-1:0]  mem_addr_out,
  input  logic                   mem_gnt_in,
  input  logic                   mem_rvalid_in,
  input  logic [INSTR_WIDTH-1:0] mem_rdata_in,
  output logic                   instr_valid_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  instr_pc_out,
  input  logic                   instr_ready_in,
  input  logic                   redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_in,
  output logic                   fetch_fault_out
);

  fetch_state_t            r_state;
  logic [ADDR_WIDTH-1:0]   r_fetch_pc;
  logic [ADDR_WIDTH-1:0]   r_last_addr;
  logic [ADDR_WIDTH-1:0]   r_instr_pc;
  logic [INSTR_WIDTH-1:0]  r_instr;
  logic                    r_fault;

  logic [ADDR_WIDTH-1:0]   w_tgt;
  logic                    w_mis;
  logic [ADDR_WIDTH-1:0]   w_pc_inc;
  logic                    w_fault_nx;
  fetch_state_t            w_go;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_tgt = redirect_pc_in;
  assign w_mis = |redirect_pc_in[1:0];
`else
  assign w_tgt = redirect_pc_in & ~ADDR_WIDTH'(3);
  assign w_mis = 1'b0;
`endif

  assign w_pc_inc   = r_fetch_pc + ADDR_WIDTH'(PC_STEP);
  assign w_fault_nx = redirect_valid_in ? w_mis : r_fault;
  // Where a redirect lands when nothing is left in flight.
  assign w_go       = w_mis ? FS_FAULT : FS_REQ;

  assign mem_req_out     = (r_state == FS_REQ);
  assign mem_addr_out    = mem_req_out ? r_fetch_pc : r_last_addr;
  assign instr_valid_out = (r_state == FS_HOLD);
  assign instr_out       = r_instr;
  assign instr_pc_out    = r_instr_pc;
  assign fetch_fault_out = r_fault;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state     <= FS_IDLE;
      r_fetch_pc  <= RESET_VECTOR;
      r_last_addr <= '0;
      r_instr_pc  <= '0;
      r_instr     <= '0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        FS_IDLE: begin
          r_state <= redirect_valid_in ? w_go : FS_REQ;
          r_fetch_pc <= RESET_VECTOR;
        end
        FS_REQ: begin
          r_last_addr <= r_fetch_pc;
          if (mem_gnt_in)
            r_state <= redirect_valid_in ? FS_DRAIN : FS_WAIT;
          else if (redirect_valid_in)
            r_state <= w_go;
        end
        FS_WAIT: begin
          if (mem_rvalid_in) begin
            if (redirect_valid_in) begin
              r_state <= w_go;
            end else begin
              r_instr    <= mem_rdata_in;
              r_instr_pc <= r_fetch_pc;
              r_fetch_pc <= w_pc_inc;
              r_state    <= FS_HOLD;
            end
          end else if (redirect_valid_in) begin
            r_state <= FS_DRAIN;
          end
        end
        FS_DRAIN: begin
          if (mem_rvalid_in)
            r_state <= w_fault_nx ? FS_FAULT : FS_REQ;
        end
        FS_HOLD: begin
          if (redirect_valid_in)
            r_state <= w_go;
          else if (instr_ready_in)
            r_state <= FS_REQ;
        end
        FS_FAULT: begin
          if (redirect_valid_in && !w_mis)
            r_state <= FS_REQ;
        end
        default: r_state <= FS_IDLE;
      endcase
      // Redirect target wins over any sequential PC update made above.
      if (redirect_valid_in) begin
        r_fault <= w_mis;
        if (!w_mis)
          r_fetch_pc <= w_tgt;
      end
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH_POW, default 6, SHALL set the address width exponent.
REQ-002 Parameter ADDR_WIDTH, default 1 << ADDR_WIDTH_POW, SHALL set the PC/address width.
REQ-003 Parameter RESET_VECTOR, default 0, SHALL set the first fetch address.
REQ-004 clk_in  input  1  clock; all state SHALL update on posedge clk_in only.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 mem_req_out  output  1  instruction-memory request.
REQ-007 mem_addr_out  output  ADDR_WIDTH  request address.
REQ-008 mem_gnt_in  input  1  request accepted this cycle.
REQ-009 mem_rvalid_in  input  1  response data valid.
REQ-010 mem_rdata_in  input  32  response instruction word.
REQ-011 instr_valid_out  output  1  fetched instruction available to decode.
REQ-012 instr_out  output  32  fetched instruction.
REQ-013 instr_pc_out  output  ADDR_WIDTH  address of instr_out.
REQ-014 instr_ready_in  input  1  decode accepts instr_out.
REQ-015 redirect_valid_in  input  1  branch/jump/trap redirect.
REQ-016 redirect_pc_in  input  ADDR_WIDTH  redirect target.
REQ-017 fetch_fault_out  output  1  misaligned-target fault (REQ-036).

Function
REQ-018 States SHALL be IDLE, REQ, WAIT, DRAIN, HOLD, FAULT; at most one memory transaction outstanding.
REQ-019 IDLE: lasts exactly one cycle after reset deassertion, then REQ with fetch_pc = RESET_VECTOR.
REQ-020 REQ: mem_req_out=1, mem_addr_out=fetch_pc; mem_gnt_in -> WAIT.
REQ-021 WAIT: mem_rvalid_in -> capture mem_rdata_in into instr_out, fetch_pc into instr_pc_out, fetch_pc += 4, -> HOLD.
REQ-022 HOLD: instr_valid_out=1, instr_out/instr_pc_out stable; instr_ready_in -> REQ, instr_valid_out=0 next cycle.
REQ-023 mem_req_out SHALL be 0 in every state except REQ; mem_addr_out SHALL hold last value outside REQ.
REQ-024 PC increment SHALL wrap modulo 2^ADDR_WIDTH (all-ones minus 3 + 4 -> 0).
REQ-025 Redirect in IDLE or REQ (including same cycle as mem_gnt_in without grant taken): fetch_pc <= redirect_pc_in; in REQ with simultaneous gnt, granted request SHALL be treated as in-flight -> DRAIN.
REQ-026 Redirect in WAIT without mem_rvalid_in: fetch_pc <= redirect_pc_in, -> DRAIN; DRAIN discards next rvalid, then -> REQ.
REQ-027 Redirect in WAIT with same-cycle mem_rvalid_in: response discarded, -> REQ at redirect_pc_in.
REQ-028 Redirect in HOLD: instr_valid_out=0 next cycle, -> REQ at redirect_pc_in; redirect SHALL win over same-cycle instr_ready_in.
REQ-029 Redirect in DRAIN: fetch_pc updated, still discard the pending response.
REQ-030 Discarded responses SHALL never raise instr_valid_out.

Reset
REQ-031 reset SHALL override all inputs, including mid-transaction; any outstanding response after reset is ignored until first REQ.
REQ-032 Reset values: state=IDLE, fetch_pc=RESET_VECTOR, mem_req_out=0, mem_addr_out=0, instr_valid_out=0, instr_out=0, instr_pc_out=0, fetch_fault_out=0.

Configuration
REQ-033 Macro FETCH_MISALIGN_TRAP_EN SHALL select misaligned-redirect handling.
REQ-034 Defined: redirect_pc_in[1:0] != 0 -> FAULT; fetch_fault_out=1, no requests; only a later aligned redirect -> REQ (in-flight response still drained first).
REQ-035 Not defined: redirect_pc_in[1:0] forced to 0; FAULT unreachable; fetch_fault_out tied 0.
REQ-036 Misalignment check SHALL apply only to redirects; sequential fetch is always aligned.

Structure
REQ-037 Package fetch_pkg SHALL hold the state enum typedef and the instruction-width (32) and PC-step (4) constants.
REQ-038 Single module, no sub-modules; next-PC adder inline.

Verification
REQ-039 Reset, gnt/rvalid one cycle after each request, ready=1 -> fetch addresses 0x0, 0x4, 0x8 with matching instr_pc_out.
REQ-040 instr_ready_in=0 for 5 cycles in HOLD -> instr_out/instr_pc_out stable, mem_req_out=0 throughout.
REQ-041 Redirect to 0x40 in WAIT, rvalid two cycles later with 0xDEADBEEF -> data dropped, next mem_addr_out=0x40.
REQ-042 Redirect to 0x80 with same-cycle instr_ready_in in HOLD -> valid drops, next request 0x80.
REQ-043 Redirect to 0xFFFF_FFFF_FFFF_FFFC, fetch -> next address 0x0.
REQ-044 With FETCH_MISALIGN_TRAP_EN, redirect to 0x42 -> fetch_fault_out=1, no requests; redirect 0x44 -> fault clears, request 0x44; without macro, 0x42 -> request 0x40.
